// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - register map and counter constants shared by pwm_capture and its channels
package pwm_capture_pkg;

    localparam int NUM_CH = 3;

    localparam logic [4:0] ADDR_HIGH0   = 5'd0;
    localparam logic [4:0] ADDR_HIGH1   = 5'd4;
    localparam logic [4:0] ADDR_HIGH2   = 5'd8;
    localparam logic [4:0] ADDR_PERIOD0 = 5'd12;
    localparam logic [4:0] ADDR_PERIOD1 = 5'd16;
    localparam logic [4:0] ADDR_PERIOD2 = 5'd20;
    localparam logic [4:0] ADDR_STATUS  = 5'd24;
    localparam logic [4:0] ADDR_CTRL    = 5'd28;

    localparam int STATUS_VALID_LSB = 0;
    localparam int STATUS_OVF_LSB   = 3;

    localparam logic [7:0] CNT_MAX    = 8'hFF;
    localparam logic [7:0] CTRL_RESET = 8'h07;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + 8'd1;
    endfunction

endpackage

// File: rtl/pwm_capture_chan.sv
// rtl/pwm_capture_chan.sv - one capture channel: sync, optional deglitch (PWM_CAPTURE_DEGLITCH_EN), counters, capture
module pwm_capture_chan
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pwm_in,
    output logic [7:0] high,
    output logic [7:0] period,
    output logic       valid_set,
    output logic       ovf_set
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_param
        $error("pwm_capture_chan: SYNC_STAGES must be 2..3 and FILT_LEN 2..15");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   armed;
    logic [7:0]             pcnt;
    logic [7:0]             hcnt;

    // The synchronizer runs even while the channel is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

    logic [3:0] filt_cnt;

    // s follows the synced input only after FILT_LEN consecutive disagreeing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            s        <= 1'b0;
            filt_cnt <= '0;
        end else if (sync_out == s) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            s        <= sync_out;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 4'd1;
        end
    end
`else
    assign s = sync_out;
`endif

    assign rise      = s & ~s_d;
    assign valid_set = en & rise & armed;
    assign ovf_set   = en & ~rise & ((pcnt == CNT_MAX) | (s & (hcnt == CNT_MAX)));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            s_d   <= 1'b0;
            armed <= 1'b0;
            pcnt  <= '0;
            hcnt  <= '0;
        end else begin
            s_d <= s;
            if (rise) begin
                pcnt  <= 8'd1;
                hcnt  <= 8'd1;
                armed <= 1'b1;
            end else begin
                pcnt <= sat_inc(pcnt);
                if (s) begin
                    hcnt <= sat_inc(hcnt);
                end
            end
        end
    end

    // Results survive a disable; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            high   <= '0;
            period <= '0;
        end else if (valid_set) begin
            high   <= hcnt;
            period <= pcnt;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - three-channel PWM high-time/period capture with byte register bus (PWM_CAPTURE_DEGLITCH_EN selects input filter)
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_en,
    input  logic [4:0] addr,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic [2:0] pwm_in
);

    logic [NUM_CH-1:0]      ctrl_en;
    logic [NUM_CH-1:0]      status_valid;
    logic [NUM_CH-1:0]      status_ovf;
    logic [NUM_CH-1:0]      valid_set;
    logic [NUM_CH-1:0]      ovf_set;
    logic [NUM_CH-1:0]      clr_valid;
    logic [NUM_CH-1:0]      clr_ovf;
    logic [NUM_CH-1:0][7:0] high_q;
    logic [NUM_CH-1:0][7:0] period_q;
    logic                   status_wr;
    logic                   ctrl_wr;
    logic [7:0]             rd_mux;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
        pwm_capture_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en        (ctrl_en[n]),
            .pwm_in    (pwm_in[n]),
            .high      (high_q[n]),
            .period    (period_q[n]),
            .valid_set (valid_set[n]),
            .ovf_set   (ovf_set[n])
        );
    end

    assign status_wr = wr_en && (addr == ADDR_STATUS);
    assign ctrl_wr   = wr_en && (addr == ADDR_CTRL);
    assign clr_valid = status_wr ? wr_data[STATUS_VALID_LSB +: NUM_CH] : '0;
    assign clr_ovf   = status_wr ? wr_data[STATUS_OVF_LSB +: NUM_CH] : '0;

    // A set event in the same cycle as a write-1-to-clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en      <= CTRL_RESET[NUM_CH-1:0];
            status_valid <= '0;
            status_ovf   <= '0;
        end else begin
            if (ctrl_wr) begin
                ctrl_en <= wr_data[NUM_CH-1:0];
            end
            status_valid <= (status_valid & ~clr_valid) | valid_set;
            status_ovf   <= (status_ovf & ~clr_ovf) | ovf_set;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_HIGH0:   rd_mux = high_q[0];
            ADDR_HIGH1:   rd_mux = high_q[1];
            ADDR_HIGH2:   rd_mux = high_q[2];
            ADDR_PERIOD0: rd_mux = period_q[0];
            ADDR_PERIOD1: rd_mux = period_q[1];
            ADDR_PERIOD2: rd_mux = period_q[2];
            ADDR_STATUS:  rd_mux = {2'b00, status_ovf, status_valid};
            ADDR_CTRL:    rd_mux = {5'b00000, ctrl_en};
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule
